// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the two-port block-ROM arbiter.
package rom_arb_pkg;

    localparam int unsigned AW_DEF = 10;
    localparam int unsigned DW_DEF = 16;
    localparam int unsigned LW_DEF = 4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } arb_state_e;

    typedef struct packed {
        logic vld;
        logic last;
        logic owner;
    } pipe_ent_t;

endpackage

// File: rtl/rom_rd_pipe.sv
// Two-stage tracker shadowing the ROM read latency: stage 1 drives the output-register
// enable, stage 2 steers valid/last to the requester that owns the returning word.
module rom_rd_pipe
    import rom_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  pipe_ent_t  ent_i,
    output logic       regce_o,
    output logic [1:0] vld_o,
    output logic [1:0] last_o
);

    pipe_ent_t s1_q, s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= ent_i;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        regce_o = s1_q.vld;
        vld_o   = '0;
        last_o  = '0;
        vld_o[s2_q.owner]  = s2_q.vld;
        last_o[s2_q.owner] = s2_q.vld & s2_q.last;
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin burst arbiter sharing one registered-output block ROM between the DNA checker
// (requester 0) and the key/patch fetcher (requester 1).
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned LW = LW_DEF
) (
    input  logic          clk4,
    input  logic          reset,
    input  logic          r0_req,
    input  logic [AW-1:0] r0_addr,
    input  logic [LW-1:0] r0_len,
    output logic          r0_gnt,
    output logic          r0_vld,
    output logic          r0_last,
    output logic [DW-1:0] r0_data,
    input  logic          r1_req,
    input  logic [AW-1:0] r1_addr,
    input  logic [LW-1:0] r1_len,
    output logic          r1_gnt,
    output logic          r1_vld,
    output logic          r1_last,
    output logic [DW-1:0] r1_data,
    output logic          rom_ena,
    output logic          rom_regce,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          busy
);

    arb_state_e    state_q, state_d;
    logic          drn_q, drn_d;
    logic          last_q, last_d;   // requester served most recently
    logic          own_q, own_d;
    logic [AW-1:0] cur_q, cur_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          win;
    logic          start;
    pipe_ent_t     ent;
    logic [1:0]    vld, last;

    always_ff @(posedge clk4) begin
        if (reset) begin
            state_q <= StIdle;
            drn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drn_q   <= drn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drn_d   = (state_q == StDrain) & ~drn_q;
        unique case (state_q)
            StIdle:  if (r0_req | r1_req) state_d = StIssue;
            StIssue: if (cnt_q == '0) state_d = StDrain;
            StDrain: if (drn_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Reset leaves last_q at 1 so requester 0 wins the first contended round.
    assign win   = (r0_req & r1_req) ? ~last_q : r1_req;
    assign start = (state_q == StIdle) & (r0_req | r1_req);

    always_comb begin
        cur_d  = cur_q;
        cnt_d  = cnt_q;
        own_d  = own_q;
        last_d = last_q;
        gnt_d  = '0;
        if (start) begin
            own_d      = win;
            last_d     = win;
            gnt_d[win] = 1'b1;
            cur_d      = win ? r1_addr : r0_addr;
            cnt_d      = win ? r1_len : r0_len;
        end else if (state_q == StIssue) begin
            cur_d = cur_q + AW'(1);
            cnt_d = cnt_q - LW'(1);
        end
    end

    always_ff @(posedge clk4) begin
        if (reset) begin
            cur_q  <= '0;
            cnt_q  <= '0;
            own_q  <= 1'b0;
            last_q <= 1'b1;
            gnt_q  <= '0;
        end else begin
            cur_q  <= cur_d;
            cnt_q  <= cnt_d;
            own_q  <= own_d;
            last_q <= last_d;
            gnt_q  <= gnt_d;
        end
    end

    always_comb begin
        rom_ena   = (state_q == StIssue);
        rom_addr  = cur_q;
        busy      = (state_q != StIdle);
        ent.vld   = rom_ena;
        ent.last  = (cnt_q == '0);
        ent.owner = own_q;
        r0_gnt    = gnt_q[0];
        r1_gnt    = gnt_q[1];
        r0_vld    = vld[0];
        r1_vld    = vld[1];
        r0_last   = last[0];
        r1_last   = last[1];
        r0_data   = vld[0] ? rom_data : '0;
        r1_data   = vld[1] ? rom_data : '0;
    end

    rom_rd_pipe u_rd_pipe (
        .clk_i   (clk4),
        .rst_i   (reset),
        .ent_i   (ent),
        .regce_o (rom_regce),
        .vld_o   (vld),
        .last_o  (last)
    );

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Shares the single-port 1K×16 block ROM (ena/regcea, registered output) between two requesters: requester 0 is the DNA checker, requester 1 the key/patch fetcher. Each requester asks for a burst of consecutive words. The block grants round-robin, issues one ROM read per cycle, and steers returning data to the owner with valid/last strobes. It sits between the requesters and the ROM in the top level. It gates `rom_ena`/`rom_regce` to save power when idle.

## Interface
Parameters:
- AW, 10, ROM address width
- DW, 16, ROM data width
- LW, 4, burst-length field width; bursts are 1..2^LW words

Ports:
- clk4  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- rN_req  in  1  request, N∈{0,1}; held high until `rN_gnt`
- rN_addr  in  AW  burst start address, sampled in the grant cycle
- rN_len  in  LW  burst length minus one, sampled in the grant cycle
- rN_gnt  out  1  one-cycle grant pulse
- rN_vld  out  1  `rN_data` valid this cycle
- rN_last  out  1  final word of burst, coincides with `rN_vld`
- rN_data  out  DW  read data (ROM output passthrough)
- rom_ena  out  1  ROM enable/read strobe
- rom_regce  out  1  ROM output-register enable
- rom_addr  out  AW  ROM address
- rom_data  in  DW  ROM output
- busy  out  1  high in ISSUE or DRAIN

## Operation
- The FSM has three states: IDLE, ISSUE, DRAIN.
- **IDLE**
  - If any `rN_req` is high, select the winner, latch its addr and len, and go to ISSUE.
  - `rN_gnt` for the winner is registered and goes high in the first ISSUE cycle.
- **Arbitration**
  - With a single request, that requester wins.
  - With both requesting, the requester not served last wins.
  - After reset, requester 0 has priority.
- **ISSUE**
  - Each cycle: `rom_ena`=1, `rom_addr`=cur, cur←cur+1 modulo 2^AW. 0x3FF wraps to 0x000 with no error.
  - The beat counter counts down from len.
  - At count 0, go to DRAIN.
- **DRAIN**
  - Lasts exactly 2 cycles, emptying the read pipe, then returns to IDLE.
  - A request arriving during ISSUE or DRAIN waits. It is evaluated in IDLE.
- **Read pipe (2 stages, carrying valid, last, owner)**
  - An issue at cycle k produces `rom_regce`=1 at k+1.
  - The owner's `rN_vld` is high at k+2, with `rN_data`=`rom_data`.
  - `rN_last` is high on the beat issued with count 0.
- `rom_ena` and `rom_regce` are 0 whenever no read is in flight.
- If a requester drops `rN_req` before it is granted, nothing happens: no grant and no error.
- `rN_addr`/`rN_len` changes after the grant cycle have no effect.

## Timing
- Reset value of every output: `rN_gnt`, `rN_vld`, `rN_last`, `rom_ena`, `rom_regce`, `busy` = 0; `rom_addr`, `rN_data` = 0.
- **Request to grant:** `rN_req` sampled high in IDLE at cycle T gives `rN_gnt`=1 and the first `rom_ena` at T+1.
- **Data latency:** the first `rN_vld` is at T+3, and a burst of L words delivers `vld` on T+3..T+2+L.
- **Next grant:** the earliest next grant is at T+L+4, since IDLE at T+L+3 evaluates requests. For example, len=0 gives grants every 4 cycles when requests are continuous.
- **Reset mid-burst:** on the cycle after reset is sampled, all outputs are 0, in-flight data is discarded (no vld), and the FSM returns to IDLE with priority to requester 0.
- `rN_vld`/`rN_last`/`rN_data` are stable only in valid cycles. Requesters must not sample them otherwise.

## Structure
- **Package `rom_arb_pkg`:** state enum (IDLE, ISSUE, DRAIN), default AW/DW/LW constants, and a pipe-entry struct {vld, last, owner}.
- **Sub-module `rom_rd_pipe`:** 2-stage shift register of pipe entries. It produces `rom_regce` from stage 1 and owner-steered vld/last from stage 2.
- The top holds the FSM, round-robin pointer, address counter and beat counter.
- Use a behavioural ROM model with a 2-cycle registered-output latency in the bench.

## Test plan
- After reset, r0 requests addr=0x010, len=3 → r0_gnt at T+1; rom_addr 0x010..0x013 on T+1..T+4; r0_vld T+3..T+6 with ROM[0x010..0x013]; r0_last at T+6 only.
- r0 and r1 both request in the same IDLE cycle after reset → r0 granted first. While both keep requesting, grants alternate r1, r0, r1, and r0_vld and r1_vld are never high together.
- r1 requests addr=0x3FE, len=3 → rom_addr sequence 0x3FE, 0x3FF, 0x000, 0x001, and data matches ROM at those addresses.
- Continuous r0 requests with len=0 → r0_gnt every 4 cycles. rom_ena is high 1 cycle in 4 and rom_regce the cycle after.
- Reset asserted on the 2nd ISSUE cycle of a len=7 burst → next cycle all outputs 0, no further vld for that burst. A following r1 request is served normally, and a simultaneous r0/r1 request then goes to r0.
- r0 drops r0_req during r1's burst before being granted → no r0_gnt, and the FSM stays in IDLE after DRAIN with rom_ena=0.
